// File: rtl/cnet_reg_slave_pkg.sv
// Shared definitions for the CNET-side register slave: bus widths, local
// register offsets, the read value returned by a timed-out access, and the
// slave FSM state encoding.
package cnet_reg_slave_pkg;

  localparam int CPCI_CNET_ADDR_WIDTH = 27;
  localparam int CPCI_CNET_DATA_WIDTH = 32;

  // Byte offsets inside the 16-byte local block
  localparam logic [3:0] OFS_ID          = 4'h0;
  localparam logic [3:0] OFS_CONTROL     = 4'h4;
  localparam logic [3:0] OFS_TIMEOUT_CNT = 4'h8;

  localparam logic [31:0] TIMEOUT_RD_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOCAL_RD = 2'd1,
    ST_FWD      = 2'd2,
    ST_RD_REPLY = 2'd3
  } state_e;

endpackage

// File: rtl/cnet_reg_slave_local_regs.sv
// Local register block of the CNET register slave.
//   clk, reset     : clock, async active-high reset
//   wr_en          : write strobe (one cycle)
//   word_sel       : word index inside the 16-byte block (addr[3:2])
//   wr_data        : write data
//   timeout_inc    : bump the saturating forwarded-access timeout count
//   rd_data        : combinational read mux for word_sel
//   control        : CONTROL register contents
module cnet_reg_slave_local_regs
  import cnet_reg_slave_pkg::*;
#(
  parameter int                    DATA_WIDTH = CPCI_CNET_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] DEVICE_ID  = 32'h0001_C4E7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [1:0]            word_sel,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  timeout_inc,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] control
);

  logic [DATA_WIDTH-1:0] control_q, control_d;
  logic [15:0]           timeout_cnt_q, timeout_cnt_d;

  always_comb begin
    control_d     = control_q;
    timeout_cnt_d = timeout_cnt_q;
    // Only CONTROL is writable; ID, TIMEOUT_CNT and the spare word drop writes
    if (wr_en && (word_sel == OFS_CONTROL[3:2])) control_d = wr_data;
    if (timeout_inc && (timeout_cnt_q != 16'hFFFF)) timeout_cnt_d = timeout_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      control_q     <= '0;
      timeout_cnt_q <= '0;
    end else begin
      control_q     <= control_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (word_sel)
      OFS_ID[3:2]:          rd_data = DEVICE_ID;
      OFS_CONTROL[3:2]:     rd_data = control_q;
      OFS_TIMEOUT_CNT[3:2]: rd_data = DATA_WIDTH'(timeout_cnt_q);
      default:              rd_data = '0;
    endcase
  end

  assign control = control_q;

endmodule

// File: rtl/cnet_reg_slave.sv
// CNET-side terminator of the CPCI<->CNET register bus. Registers the pin
// request, serves the local ID/CONTROL/TIMEOUT_CNT block and forwards every
// other address to the internal register bus under a timeout.
//   clk, reset                      : clock, async active-high reset
//   cpci_req/rd_wr_L/addr/data_in   : request from CPCI (held until acked)
//   cpci_data_out, cpci_data_tri_en : read data and its bus drive enable
//   cpci_wr_rdy                     : slave idle
//   cpci_rd_rdy                     : one-cycle read data valid
//   reg_req/rd_wr_L/addr/wr_data    : internal bus request, held until reg_ack
//   reg_ack, reg_rd_data            : internal bus completion and read data
//   control                         : CONTROL register contents
//
// state       | meaning
// ------------+-----------------------------------------------------
// ST_IDLE     | waiting for a request edge; local writes commit here
// ST_LOCAL_RD | latching the local register read value
// ST_FWD      | internal bus request outstanding, timeout timer running
// ST_RD_REPLY | driving read data with cpci_rd_rdy for one cycle
module cnet_reg_slave
  import cnet_reg_slave_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = CPCI_CNET_ADDR_WIDTH,
  parameter int                    DATA_WIDTH     = CPCI_CNET_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] LOCAL_BASE     = 27'h040_0000,
  parameter logic [DATA_WIDTH-1:0] DEVICE_ID      = 32'h0001_C4E7,
  parameter int                    TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpci_req,
  input  logic                  cpci_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0] cpci_addr,
  input  logic [DATA_WIDTH-1:0] cpci_data_in,
  output logic [DATA_WIDTH-1:0] cpci_data_out,
  output logic                  cpci_data_tri_en,
  output logic                  cpci_wr_rdy,
  output logic                  cpci_rd_rdy,
  output logic                  reg_req,
  output logic                  reg_rd_wr_L,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  input  logic                  reg_ack,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic [DATA_WIDTH-1:0] control
);

  localparam int                TIMER_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  // Input stage
  logic                  req_q, req_q_d1, rd_wr_l_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q     <= 1'b0;
      req_q_d1  <= 1'b0;
      rd_wr_l_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      req_q     <= cpci_req;
      req_q_d1  <= req_q;
      rd_wr_l_q <= cpci_rd_wr_L;
      addr_q    <= cpci_addr;
      data_q    <= cpci_data_in;
    end
  end

  logic start, is_local;
  assign start    = req_q && !req_q_d1;
  assign is_local = (addr_q[ADDR_WIDTH-1:4] == LOCAL_BASE[ADDR_WIDTH-1:4]);

  state_e                state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [ADDR_WIDTH-1:0] xact_addr_q, xact_addr_d;
  logic [DATA_WIDTH-1:0] xact_data_q, xact_data_d;
  logic                  xact_rd_q, xact_rd_d;
  logic                  local_wr_en, timeout_inc;
  logic [1:0]            local_sel;
  logic [DATA_WIDTH-1:0] local_rd_data;

  // Local writes decode straight from the input stage in IDLE; local reads
  // use the latched address one cycle later.
  assign local_sel = (state_q == ST_IDLE) ? addr_q[3:2] : xact_addr_q[3:2];

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    rd_data_d   = rd_data_q;
    xact_addr_d = xact_addr_q;
    xact_data_d = xact_data_q;
    xact_rd_d   = xact_rd_q;
    local_wr_en = 1'b0;
    timeout_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          xact_addr_d = addr_q;
          xact_data_d = data_q;
          xact_rd_d   = rd_wr_l_q;
          if (is_local) begin
            if (rd_wr_l_q) state_d = ST_LOCAL_RD;
            else           local_wr_en = 1'b1;
          end else begin
            state_d = ST_FWD;
            timer_d = '0;
          end
        end
      end
      ST_LOCAL_RD: begin
        rd_data_d = local_rd_data;
        state_d   = ST_RD_REPLY;
      end
      ST_FWD: begin
        // An ack on the expiry cycle wins over the timeout
        if (reg_ack) begin
          if (xact_rd_q) begin
            rd_data_d = reg_rd_data;
            state_d   = ST_RD_REPLY;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (timer_q == TIMER_LAST) begin
          timeout_inc = 1'b1;
          if (xact_rd_q) begin
            rd_data_d = DATA_WIDTH'(TIMEOUT_RD_DATA);
            state_d   = ST_RD_REPLY;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_RD_REPLY: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      rd_data_q   <= '0;
      xact_addr_q <= '0;
      xact_data_q <= '0;
      xact_rd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      rd_data_q   <= rd_data_d;
      xact_addr_q <= xact_addr_d;
      xact_data_q <= xact_data_d;
      xact_rd_q   <= xact_rd_d;
    end
  end

  cnet_reg_slave_local_regs #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEVICE_ID  (DEVICE_ID)
  ) u_local_regs (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (local_wr_en),
    .word_sel    (local_sel),
    .wr_data     (data_q),
    .timeout_inc (timeout_inc),
    .rd_data     (local_rd_data),
    .control     (control)
  );

  // State-decoded outputs so an async reset drops reg_req immediately
  assign cpci_wr_rdy      = (state_q == ST_IDLE);
  assign cpci_rd_rdy      = (state_q == ST_RD_REPLY);
  assign cpci_data_tri_en = (state_q == ST_RD_REPLY);
  assign cpci_data_out    = (state_q == ST_RD_REPLY) ? rd_data_q : '0;
  assign reg_req          = (state_q == ST_FWD);
  assign reg_rd_wr_L      = xact_rd_q;
  assign reg_addr         = xact_addr_q;
  assign reg_wr_data      = xact_data_q;

endmodule

// File: tb/tb_cnet_reg_slave.sv
module tb_cnet_reg_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpci_req, cpci_rd_wr_L;
  logic [26:0] cpci_addr;
  logic [31:0] cpci_data_in, cpci_data_out;
  logic        cpci_data_tri_en, cpci_wr_rdy, cpci_rd_rdy;
  logic        reg_req, reg_rd_wr_L, reg_ack;
  logic [26:0] reg_addr;
  logic [31:0] reg_wr_data, reg_rd_data, control;

  cnet_reg_slave dut (
    .clk              (clk),
    .reset            (reset),
    .cpci_req         (cpci_req),
    .cpci_rd_wr_L     (cpci_rd_wr_L),
    .cpci_addr        (cpci_addr),
    .cpci_data_in     (cpci_data_in),
    .cpci_data_out    (cpci_data_out),
    .cpci_data_tri_en (cpci_data_tri_en),
    .cpci_wr_rdy      (cpci_wr_rdy),
    .cpci_rd_rdy      (cpci_rd_rdy),
    .reg_req          (reg_req),
    .reg_rd_wr_L      (reg_rd_wr_L),
    .reg_addr         (reg_addr),
    .reg_wr_data      (reg_wr_data),
    .reg_ack          (reg_ack),
    .reg_rd_data      (reg_rd_data),
    .control          (control)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Transaction-level model: windows of cycles in which each output is active
  int          m_busy_lo = -1, m_busy_hi = -2;
  int          m_fwd_lo  = -1, m_fwd_hi  = -2;
  int          m_rd_cyc  = -1;
  logic [31:0] m_rd_data = '0;
  logic [26:0] m_reg_addr = '0;
  logic [31:0] m_reg_wdata = '0;
  logic        m_reg_rd = 1'b0;
  logic [31:0] m_ctrl_old = '0, m_ctrl_new = '0;
  int          m_ctrl_cyc = -1;
  int          m_timeouts = 0;

  // Drive-side schedule for the current transaction
  int          g_start = 0, g_end = 0, g_ack_cyc = -1;
  logic [31:0] g_ack_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic        in_rd, in_fwd, in_busy;
    logic [31:0] exp_ctrl;
    in_rd    = (cyc == m_rd_cyc);
    in_fwd   = (cyc >= m_fwd_lo) && (cyc <= m_fwd_hi);
    in_busy  = (cyc >= m_busy_lo) && (cyc <= m_busy_hi);
    exp_ctrl = (m_ctrl_cyc >= 0 && cyc >= m_ctrl_cyc) ? m_ctrl_new : m_ctrl_old;
    check("rd_rdy",   32'(cpci_rd_rdy),      32'(in_rd));
    check("tri_en",   32'(cpci_data_tri_en), 32'(in_rd));
    check("data_out", cpci_data_out,         in_rd ? m_rd_data : 32'h0);
    check("wr_rdy",   32'(cpci_wr_rdy),      32'(!in_busy));
    check("reg_req",  32'(reg_req),          32'(in_fwd));
    check("control",  control,               exp_ctrl);
    if (in_fwd) begin
      check("reg_addr",    32'(reg_addr),    32'(m_reg_addr));
      check("reg_wr_data", reg_wr_data,      m_reg_wdata);
      check("reg_rd_wr_L", 32'(reg_rd_wr_L), 32'(m_reg_rd));
    end
  end

  // Called #1 after a posedge; the pins rise in cycle k = cyc.
  // ack_d: ack on the ack_d-th cycle of reg_req (1..64), otherwise none.
  task automatic start_xact(input logic rd, input logic [26:0] addr, input logic [31:0] data,
                            input int ack_d, input logic [31:0] ack_data);
    int   k, a;
    logic timed_out;
    logic [1:0] sel;
    k = cyc;
    g_start = k;
    g_ack_cyc = -1;
    g_ack_data = ack_data;
    cpci_req = 1'b1;
    cpci_rd_wr_L = rd;
    cpci_addr = addr;
    cpci_data_in = data;
    m_ctrl_old = m_ctrl_new;
    sel = addr[3:2];
    if (addr[26:4] == 23'h04_0000) begin
      if (rd) begin
        m_busy_lo = k + 2; m_busy_hi = k + 3;
        m_rd_cyc  = k + 3;
        case (sel)
          2'd0: m_rd_data = 32'h0001_C4E7;
          2'd1: m_rd_data = m_ctrl_new;
          2'd2: m_rd_data = (m_timeouts > 65535) ? 32'h0000_FFFF : 32'(m_timeouts);
          default: m_rd_data = 32'h0;
        endcase
        g_end = k + 3;
      end else begin
        if (sel == 2'd1) begin
          m_ctrl_new = data;
          m_ctrl_cyc = k + 2;
        end
        g_end = k + 2;
      end
    end else begin
      timed_out = !(ack_d >= 1 && ack_d <= 64);
      a = timed_out ? k + 65 : k + 1 + ack_d;
      if (timed_out) m_timeouts++;
      else g_ack_cyc = a;
      m_fwd_lo = k + 2; m_fwd_hi = a;
      m_reg_addr = addr; m_reg_wdata = data; m_reg_rd = rd;
      m_busy_lo = k + 2;
      if (rd) begin
        m_busy_hi = a + 1;
        m_rd_cyc  = a + 1;
        m_rd_data = timed_out ? 32'hDEAD_BEEF : ack_data;
        g_end = a + 1;
      end else begin
        m_busy_hi = a;
        g_end = a;
      end
    end
  endtask

  task automatic finish_xact(input int glitch, output int rd_off, output logic [31:0] rd_val,
                             output int req_cnt);
    rd_off = -1; rd_val = '0; req_cnt = 0;
    while (cyc <= g_end + 1) begin
      @(negedge clk);
      if (reg_req) req_cnt++;
      if (cpci_rd_rdy) begin
        rd_off = cyc - g_start;
        rd_val = cpci_data_out;
      end
      @(posedge clk); #1;
      reg_ack = (cyc == g_ack_cyc);
      reg_rd_data = reg_ack ? g_ack_data : $urandom;
      if (glitch >= 0 && cyc == glitch) cpci_req = 1'b0;
      else if (glitch >= 0 && cyc == glitch + 1) cpci_req = 1'b1;
    end
    reg_ack = 1'b0;
    cpci_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic xact(input logic rd, input logic [26:0] addr, input logic [31:0] data,
                      input int ack_d, input logic [31:0] ack_data, input int glitch,
                      output int rd_off, output logic [31:0] rd_val, output int req_cnt);
    start_xact(rd, addr, data, ack_d, ack_data);
    finish_xact(glitch < 0 ? -1 : g_start + glitch, rd_off, rd_val, req_cnt);
  endtask

  initial begin
    int          off, rc;
    logic [31:0] val;
    reset = 1'b1;
    cpci_req = 1'b0; cpci_rd_wr_L = 1'b0; cpci_addr = '0; cpci_data_in = '0;
    reg_ack = 1'b0; reg_rd_data = '0;
    #1;
    check("rst_wr_rdy",  32'(cpci_wr_rdy), 32'h1);
    check("rst_reg_req", 32'(reg_req),     32'h0);
    check("rst_control", control,          32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a forwarded read
    xact(1'b0, 27'h040_0004, 32'h0000_0055, 0, 32'h0, -1, off, val, rc);
    check("ctrl_before_rst", control, 32'h0000_0055);
    start_xact(1'b1, 27'h000_0020, 32'h0, -1, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    check("fwd_pending", 32'(reg_req), 32'h1);
    reset = 1'b1;
    m_busy_lo = -1; m_busy_hi = -2; m_fwd_lo = -1; m_fwd_hi = -2; m_rd_cyc = -1;
    m_ctrl_old = '0; m_ctrl_new = '0; m_ctrl_cyc = -1; m_timeouts = 0;
    #1;
    check("rst_mid_reg_req", 32'(reg_req),     32'h0);
    check("rst_mid_wr_rdy",  32'(cpci_wr_rdy), 32'h1);
    check("rst_mid_control", control,          32'h0);
    cpci_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // ID read: rd_rdy exactly 3 cycles after the pins rise
    xact(1'b1, 27'h040_0000, 32'h0, 0, 32'h0, -1, off, val, rc);
    check("id_rd_latency", 32'(off), 32'd3);
    check("id_rd_value",   val,      32'h0001_C4E7);

    for (int i = 1; i <= 10; i++)
      xact(1'b0, 27'h040_0004, 32'(i), 0, 32'h0, -1, off, val, rc);
    check("ctrl_after_writes", control, 32'd10);
    xact(1'b1, 27'h040_0004, 32'h0, 0, 32'h0, -1, off, val, rc);
    check("ctrl_rd_value", val, 32'h0000_000A);

    // Writes to read-only words are dropped
    xact(1'b0, 27'h040_0000, 32'hFFFF_FFFF, 0, 32'h0, -1, off, val, rc);
    xact(1'b1, 27'h040_0000, 32'h0, 0, 32'h0, -1, off, val, rc);
    check("id_after_write", val, 32'h0001_C4E7);
    xact(1'b0, 27'h040_000B, 32'h0000_1234, 0, 32'h0, -1, off, val, rc);
    xact(1'b1, 27'h040_000C, 32'h0, 0, 32'h0, -1, off, val, rc);
    check("spare_rd_zero", val, 32'h0);

    // Forwarded write acked on the 5th request cycle
    xact(1'b0, 27'h000_0010, 32'h1234_5678, 5, 32'h0, -1, off, val, rc);
    check("fwd_wr_req_cycles", 32'(rc), 32'd5);
    check("ctrl_kept", control, 32'd10);

    // Forwarded read that never gets an ack
    xact(1'b1, 27'h000_0020, 32'h0, -1, 32'h0, -1, off, val, rc);
    check("timeout_req_cycles", 32'(rc), 32'd64);
    check("timeout_rd_value",   val,     32'hDEAD_BEEF);
    check("timeout_rd_latency", 32'(off), 32'd66);
    xact(1'b1, 27'h040_0008, 32'h0, 0, 32'h0, -1, off, val, rc);
    check("timeout_cnt_1", val, 32'h0000_0001);
    xact(1'b0, 27'h040_0008, 32'hFFFF_FFFF, 0, 32'h0, -1, off, val, rc);

    // Ack on the expiry cycle plus a request re-edge while busy
    xact(1'b1, 27'h000_0030, 32'h0, 64, 32'hCAFE_0001, 4, off, val, rc);
    check("expiry_ack_value", val,      32'hCAFE_0001);
    check("expiry_req_cycles", 32'(rc), 32'd64);
    xact(1'b1, 27'h040_0008, 32'h0, 0, 32'h0, -1, off, val, rc);
    check("timeout_cnt_still_1", val, 32'h0000_0001);

    // Forwarded read with an early ack
    xact(1'b1, 27'h000_0100, 32'h0, 2, 32'h0BAD_F00D, -1, off, val, rc);
    check("fwd_rd_value", val, 32'h0BAD_F00D);
    check("fwd_rd_latency", 32'(off), 32'd4);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
